// File: rtl/timer_pkg.sv
// timer_pkg: shared constants for the interval timer / interrupt source.
// Holds register-window offsets, TCON bit positions, the TCON register
// layout and the interrupt vector shared with the hazard/jump unit.
package timer_pkg;

    // Byte offsets of the four word registers inside the 16-byte window
    localparam logic [3:0] TH_OFF   = 4'h0;
    localparam logic [3:0] TL_OFF   = 4'h4;
    localparam logic [3:0] TCON_OFF = 4'h8;
    localparam logic [3:0] EPC_OFF  = 4'hC;

    // TCON bit indices
    localparam int unsigned TCON_ENABLE = 0;
    localparam int unsigned TCON_IRQ_EN = 1;
    localparam int unsigned TCON_STATUS = 2;

    // Fetch target taken by the hazard/jump unit on an accepted interrupt
    localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;

    // Field order matches the TCON bit layout (status=bit2 .. enable=bit0)
    typedef struct packed {
        logic status;
        logic irq_en;
        logic enable;
    } tcon_t;

    function automatic logic [31:0] tcon_word(input tcon_t t);
        return {29'b0, t};
    endfunction

endpackage

// File: rtl/timer_irq_unit_if.sv
// timer_irq_unit_if: data-memory bus slice seen by the timer.
//   mem_addr  : byte address          mem_wdata : write data
//   mem_we    : write strobe          mem_re    : read strobe
//   mem_rdata : read data returned by the slave
// master = CPU/bus side, slave = timer side.
interface timer_irq_unit_if;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );

endinterface

// File: rtl/timer_counter.sv
// timer_counter: TH (reload value) and TL (count) registers.
//   clk_i, reset_i : clock, synchronous active-high reset
//   enable_i       : count enable (TCON.ENABLE)
//   th_we_i/tl_we_i: software writes of TH / TL, data on wdata_i
//   th_o, tl_o     : current register values
//   reload_o       : high in the cycle whose rising edge reloads TL from TH
module timer_counter (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        th_we_i,
    input  logic        tl_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] th_o,
    output logic [31:0] tl_o,
    output logic        reload_o
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;

    always_comb begin
        // A software TL write overrides the reload, so no reload event either
        reload_o = enable_i & (tl_q == '1) & ~tl_we_i;
        th_d     = th_q;
        tl_d     = tl_q;
        if (th_we_i) begin
            th_d = wdata_i;
        end
        if (tl_we_i) begin
            tl_d = wdata_i;
        end else if (reload_o) begin
            tl_d = th_q;
        end else if (enable_i) begin
            tl_d = tl_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            th_q <= '0;
            tl_q <= '0;
        end else begin
            th_q <= th_d;
            tl_q <= tl_d;
        end
    end

    assign th_o = th_q;
    assign tl_o = tl_q;

endmodule

// File: rtl/timer_irq_unit.sv
// timer_irq_unit: memory-mapped interval timer and interrupt source.
//   clk, reset : clock, synchronous active-high reset
//   bus        : data-memory bus (slave modport); TH/TL/TCON/EPC window
//   pc_if      : fetch-stage PC, captured into EPC on request
//   stall      : load-use stall this cycle (defers the request)
//   redirect   : taken jump/branch in ID this cycle (defers the request)
//   Interrupt  : combinational request to the hazard/jump unit
//   epc        : latched resume address
module timer_irq_unit
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR         = 32'h4000_0000,
    parameter int unsigned VECTOR_KERNEL_BIT = 31
) (
    input  logic                    clk,
    input  logic                    reset,
    timer_irq_unit_if.slave         bus,
    input  logic [31:0]             pc_if,
    input  logic                    stall,
    input  logic                    redirect,
    output logic                    Interrupt,
    output logic [31:0]             epc
);

    tcon_t       tcon_q, tcon_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] th, tl;
    logic        reload;
    logic        in_win;
    logic        th_we, tl_we, tcon_we, epc_we;

    // Window hit requires word alignment; unaligned accesses are ignored
    assign in_win  = (bus.mem_addr[31:4] == BASE_ADDR[31:4]) &&
                     (bus.mem_addr[1:0] == 2'b00);
    assign th_we   = bus.mem_we & in_win & (bus.mem_addr[3:0] == TH_OFF);
    assign tl_we   = bus.mem_we & in_win & (bus.mem_addr[3:0] == TL_OFF);
    assign tcon_we = bus.mem_we & in_win & (bus.mem_addr[3:0] == TCON_OFF);
    assign epc_we  = bus.mem_we & in_win & (bus.mem_addr[3:0] == EPC_OFF);

    timer_counter u_counter (
        .clk_i    (clk),
        .reset_i  (reset),
        .enable_i (tcon_q.enable),
        .th_we_i  (th_we),
        .tl_we_i  (tl_we),
        .wdata_i  (bus.mem_wdata),
        .th_o     (th),
        .tl_o     (tl),
        .reload_o (reload)
    );

    // Kernel-mode PC masks nesting; stall/redirect defer until the slot is safe
    assign Interrupt = ~reset & tcon_q.status & tcon_q.irq_en &
                       ~pc_if[VECTOR_KERNEL_BIT] & ~stall & ~redirect;

    always_comb begin
        tcon_d = tcon_q;
        epc_d  = epc_q;
        if (tcon_we) begin
            tcon_d.enable = bus.mem_wdata[TCON_ENABLE];
            tcon_d.irq_en = bus.mem_wdata[TCON_IRQ_EN];
            tcon_d.status = bus.mem_wdata[TCON_STATUS];
        end
        // Reload event beats a same-cycle software clear: no lost interrupt
        if (reload && tcon_q.irq_en) begin
            tcon_d.status = 1'b1;
        end
        if (epc_we) begin
            epc_d = bus.mem_wdata;
        end
        if (Interrupt) begin
            epc_d = pc_if;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tcon_q <= '0;
            epc_q  <= '0;
        end else begin
            tcon_q <= tcon_d;
            epc_q  <= epc_d;
        end
    end

    always_comb begin
        bus.mem_rdata = '0;
        if (!reset && bus.mem_re && in_win) begin
            unique case (bus.mem_addr[3:0])
                TH_OFF:   bus.mem_rdata = th;
                TL_OFF:   bus.mem_rdata = tl;
                TCON_OFF: bus.mem_rdata = tcon_word(tcon_q);
                EPC_OFF:  bus.mem_rdata = epc_q;
                default:  bus.mem_rdata = '0;
            endcase
        end
    end

    assign epc = epc_q;

endmodule

// File: tb/tb_timer_irq_unit.sv
module tb_timer_irq_unit;
    import timer_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] A_TH = BASE + 32'h0;
    localparam logic [31:0] A_TL = BASE + 32'h4;
    localparam logic [31:0] A_TC = BASE + 32'h8;
    localparam logic [31:0] A_EP = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_if;
    logic        stall, redirect;
    logic        Interrupt;
    logic [31:0] epc;

    timer_irq_unit_if bus ();

    timer_irq_unit #(.BASE_ADDR(BASE), .VECTOR_KERNEL_BIT(31)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .pc_if     (pc_if),
        .stall     (stall),
        .redirect  (redirect),
        .Interrupt (Interrupt),
        .epc       (epc)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register contents
    logic [31:0] m_th = '0, m_tl = '0, m_epc = '0;
    logic        m_en = 1'b0, m_ien = 1'b0, m_st = 1'b0;

    int n_total = 0;
    int n_pass  = 0;
    int irq_pulses = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic m_irq();
        return !reset && m_st && m_ien && !pc_if[31] && !stall && !redirect;
    endfunction

    function automatic logic [31:0] m_read(input logic rst, input logic re, input logic [31:0] a);
        if (rst || !re) return '0;
        if ((a & 32'hFFFF_FFF0) != BASE || a[1:0] != 2'b00) return '0;
        case (a[3:2])
            2'd0:    return m_th;
            2'd1:    return m_tl;
            2'd2:    return {29'b0, m_st, m_ien, m_en};
            default: return m_epc;
        endcase
    endfunction

    // Generic per-cycle checks of every output against the model
    task automatic check_now();
        chk("irq", {31'b0, Interrupt}, {31'b0, m_irq()});
        chk("rdata", bus.mem_rdata, m_read(reset, bus.mem_re, bus.mem_addr));
        chk("epc", epc, m_epc);
        if (Interrupt) irq_pulses++;
    endtask

    // Advance one clock edge, updating the model from the sampled inputs.
    // Also plays the hazard unit: an accepted request vectors fetch.
    task automatic step_body();
        logic        exp_irq, rst_s, we_s, wr, reload, st_n;
        logic [31:0] a, d;
        exp_irq = m_irq();
        rst_s   = reset;
        we_s    = bus.mem_we;
        a       = bus.mem_addr;
        d       = bus.mem_wdata;
        @(posedge clk);
        if (rst_s) begin
            m_th = '0; m_tl = '0; m_epc = '0;
            m_en = 1'b0; m_ien = 1'b0; m_st = 1'b0;
        end else begin
            wr     = we_s && ((a & 32'hFFFF_FFF0) == BASE) && (a[1:0] == 2'b00);
            reload = m_en && (m_tl == 32'hFFFF_FFFF) && !(wr && a[3:2] == 2'd1);
            st_n   = (wr && a[3:2] == 2'd2) ? d[2] : m_st;
            if (reload && m_ien) st_n = 1'b1;
            if (wr && a[3:2] == 2'd1) m_tl = d;
            else if (reload)          m_tl = m_th;
            else if (m_en)            m_tl = m_tl + 32'd1;
            if (wr && a[3:2] == 2'd0) m_th = d;
            if (wr && a[3:2] == 2'd2) begin
                m_en  = d[0];
                m_ien = d[1];
            end
            m_st = st_n;
            if (wr && a[3:2] == 2'd3) m_epc = d;
            if (exp_irq) m_epc = pc_if;
        end
        @(negedge clk);
        if (exp_irq) pc_if = IRQ_VECTOR;
    endtask

    task automatic step();
        #1;
        check_now();
        step_body();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.mem_addr = a; bus.mem_wdata = d; bus.mem_we = 1'b1; bus.mem_re = 1'b0;
        step();
        bus.mem_we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bus.mem_addr = a; bus.mem_re = 1'b1; bus.mem_we = 1'b0;
        #1;
        chk(tag, bus.mem_rdata, exp);
        check_now();
        step_body();
        bus.mem_re = 1'b0;
    endtask

    task automatic irq_expect(input logic v, input string tag);
        #1;
        chk(tag, {31'b0, Interrupt}, {31'b0, v});
        check_now();
        step_body();
    endtask

    initial begin
        int  p0;
        bit  found;
        int  k;
        logic [31:0] a, d;

        reset = 1'b1; pc_if = 32'h0040_0010; stall = 1'b0; redirect = 1'b0;
        bus.mem_addr = A_TL; bus.mem_wdata = '0; bus.mem_we = 1'b0; bus.mem_re = 1'b1;
        #1;
        chk("rst_rdata", bus.mem_rdata, 32'h0);
        chk("rst_irq", {31'b0, Interrupt}, 32'h0);
        step_body();
        step();
        reset = 1'b0;

        // Reset values
        rd(A_TH, 32'h0, "reset_TH");
        rd(A_TL, 32'h0, "reset_TL");
        rd(A_TC, 32'h0, "reset_TCON");
        rd(A_EP, 32'h0, "reset_EPC");

        // Basic reload and single-cycle request
        wr(A_TH, 32'hFFFF_FFFC);
        wr(A_TL, 32'hFFFF_FFFE);
        p0 = irq_pulses;
        wr(A_TC, 32'h3);
        rd(A_TL, 32'hFFFF_FFFE, "count_1");
        rd(A_TL, 32'hFFFF_FFFF, "count_2");
        #1;
        chk("irq_after_reload", {31'b0, Interrupt}, 32'h1);
        rd(A_TL, 32'hFFFF_FFFC, "reload_TL");
        irq_expect(1'b0, "irq_one_cycle");
        step();
        rd(A_EP, 32'h0040_0010, "epc_capture");
        chk("pulse_count", 32'(irq_pulses - p0), 32'd1);

        // Stall defers the request, then exactly one pulse
        wr(A_TC, 32'h0);
        pc_if = 32'h0040_0010;
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TC, 32'h3);
        step();
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) irq_expect(1'b0, "stall_masks");
        stall = 1'b0;
        pc_if = 32'h0040_0020;
        p0 = irq_pulses;
        irq_expect(1'b1, "stall_release");
        step();
        chk("stall_pulses", 32'(irq_pulses - p0), 32'd1);
        rd(A_EP, 32'h0040_0020, "stall_epc");

        // Kernel PC masks; clearing STATUS keeps the user PC quiet
        pc_if = 32'h8000_0020;
        wr(A_TH, 32'h0);
        wr(A_TL, 32'h0);
        irq_expect(1'b0, "kernel_mask");
        wr(A_TC, 32'h3);
        pc_if = 32'h0040_0014;
        for (int i = 0; i < 4; i++) irq_expect(1'b0, "cleared_quiet");

        // TCON clear on the reload edge: STATUS survives
        pc_if = 32'h8000_0020;
        wr(A_TL, 32'hFFFF_FFFE);
        step();
        wr(A_TC, 32'h3);
        rd(A_TC, 32'h7, "status_wins");

        // TL write on the reload edge: software value wins
        wr(A_TC, 32'h3);
        wr(A_TL, 32'hFFFF_FFFE);
        step();
        wr(A_TL, 32'h5);
        rd(A_TL, 32'h5, "tl_write_wins");

        // Ignored writes: unaligned and outside the window
        wr(A_TH + 32'h1, 32'hDEAD_BEEF);
        wr(BASE + 32'h10, 32'hDEAD_BEEF);
        rd(A_TH, 32'h0, "bad_writes_ignored");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 3);
            a = BASE + 32'(k * 4);
            case ($urandom_range(0, 7))
                0: a = a + 32'($urandom_range(1, 3));
                1: a = BASE + 32'h10 + 32'($urandom_range(0, 3) * 4);
                2: a = 32'h1000_0000 + 32'(k * 4);
                default: ;
            endcase
            d = $urandom;
            if (k == 1 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            if (k == 0 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            if (k == 2) d = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 7)) : 32'h3;
            bus.mem_addr  = a;
            bus.mem_wdata = d;
            bus.mem_we    = ($urandom_range(0, 3) == 0);
            bus.mem_re    = ($urandom_range(0, 1) == 1);
            stall         = ($urandom_range(0, 4) == 0);
            redirect      = ($urandom_range(0, 4) == 0);
            if (pc_if != IRQ_VECTOR || $urandom_range(0, 2) == 0)
                pc_if = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h8000_0000)
                                                    : ($urandom & 32'h7FFF_FFFC);
            reset         = ($urandom_range(0, 79) == 0);
            step();
        end
        reset = 1'b0; stall = 1'b0; redirect = 1'b0;
        bus.mem_we = 1'b0; bus.mem_re = 1'b0;

        // Reset mid-count while a request is pending
        pc_if = 32'h0040_0010;
        wr(A_TH, 32'h0);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TC, 32'h3);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            #1;
            if (m_irq()) found = 1'b1;
            else begin
                check_now();
                step_body();
            end
        end
        chk("irq_before_reset", {31'b0, Interrupt}, 32'h1);
        reset = 1'b1;
        step_body();
        reset = 1'b0;
        irq_expect(1'b0, "irq_after_reset");
        rd(A_TH, 32'h0, "post_reset_TH");
        rd(A_TL, 32'h0, "post_reset_TL");
        rd(A_TC, 32'h0, "post_reset_TCON");
        rd(A_EP, 32'h0, "post_reset_EPC");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
